// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit blocks.
//   uart_rx_state_e : receiver frame-sequencing states
//   parity_calc     : expected parity bit for a data word (also used by uart_tx)
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_e;

  // Widest data word the parity helper accepts. Narrower words are
  // zero-extended by the caller, which leaves the XOR reduction unchanged.
  localparam int PARITY_MAX_WIDTH = 32;

  // typ = 0 gives even parity, typ = 1 gives odd parity. The result is the
  // parity bit that must accompany 'data' on the line.
  function automatic logic parity_calc(input logic [PARITY_MAX_WIDTH-1:0] data,
                                       input logic                        typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Line synchronizer, per-bit oversampling counter and 3-sample majority vote.
//   clk, res_n : clock and synchronous active-low reset
//   rx_in      : raw serial line (asynchronous, idle high)
//   cnt_start  : restart the bit counter (start edge seen this cycle)
//   cnt_run    : counter advances while a frame is in progress
//   rx_fall    : synchronized line fell this cycle (previous 1, current 0)
//   bit_val    : majority of the samples at cnt = H-1, H and H+1
//   bit_done   : vote strobe, high while cnt = H+1
//   bit_end    : high on the last clock of a bit period
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic res_n,
  input  logic rx_in,
  input  logic cnt_start,
  input  logic cnt_run,
  output logic rx_fall,
  output logic bit_val,
  output logic bit_done,
  output logic bit_end
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int H     = OVERSAMPLE / 2;

  localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP1 = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);

  logic             rx_meta;
  logic             rx_s;
  logic             rx_s_d;
  logic [CNT_W-1:0] cnt;
  logic             samp0;
  logic             samp1;

  // Two-flop synchronizer plus one delayed copy for edge detection. All
  // three reset to the idle level so a reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // The edge-detect cycle itself counts as cnt = 0, so the counter is loaded
  // with 1 there; this centres the vote window on the middle of each bit.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt <= '0;
    end else if (cnt_start) begin
      cnt <= CNT_W'(1);
    end else if (cnt_run) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // The first two vote samples are held; the third is the live line value
  // during the vote cycle so the decision is available at cnt = H+1.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (cnt == CNT_SAMP0) samp0 <= rx_s;
      if (cnt == CNT_SAMP1) samp1 <= rx_s;
    end
  end

  assign rx_fall  = rx_s_d & ~rx_s;
  assign bit_val  = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign bit_done = (cnt == CNT_VOTE);
  assign bit_end  = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. OVERSAMPLE must be even and >= 4.
//   clk, res_n  : clock and synchronous active-low reset
//   rx_in       : serial line, idle high, asynchronous to clk
//   par_en      : parity bit expected (latched at the start edge)
//   par_typ     : 0 even, 1 odd parity (latched at the start edge)
//   p_data      : last good received word
//   data_valid  : one-cycle pulse when p_data is updated
//   par_err     : one-cycle pulse on a parity mismatch
//   stp_err     : one-cycle pulse when the stop bit is 0
//   busy        : high while a frame is being received
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_rx_state_e        state;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  par_fail;

  logic rx_fall;
  logic bit_val;
  logic bit_done;
  logic bit_end;
  logic start_edge;
  logic cnt_run;

  assign start_edge = (state == RX_IDLE) && rx_fall;
  assign cnt_run    = (state != RX_IDLE);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk       (clk),
    .res_n     (res_n),
    .rx_in     (rx_in),
    .cnt_start (start_edge),
    .cnt_run   (cnt_run),
    .rx_fall   (rx_fall),
    .bit_val   (bit_val),
    .bit_done  (bit_done),
    .bit_end   (bit_end)
  );

  // Frame sequencer. Outputs are registered here so every pulse appears the
  // cycle after the stop-bit vote. The stop state leaves at the vote rather
  // than at the end of the bit so that a start edge arriving early in the
  // second half of the stop bit is still caught.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= RX_IDLE;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_fail   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            state     <= RX_START;
            busy      <= 1'b1;
            par_en_l  <= par_en;
            par_typ_l <= par_typ;
            par_fail  <= 1'b0;
            bit_idx   <= '0;
          end
        end

        // A start bit that votes high was a glitch: drop it silently.
        RX_START: begin
          if (bit_done && bit_val) begin
            state <= RX_IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state <= RX_DATA;
          end
        end

        RX_DATA: begin
          if (bit_done) shift_reg[bit_idx] <= bit_val;
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              state   <= par_en_l ? RX_PARITY : RX_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        RX_PARITY: begin
          if (bit_done)
            par_fail <= (bit_val != parity_calc(PARITY_MAX_WIDTH'(shift_reg), par_typ_l));
          if (bit_end) state <= RX_STOP;
        end

        RX_STOP: begin
          if (bit_done) begin
            state <= RX_IDLE;
            busy  <= 1'b0;
            if (!bit_val) begin
              stp_err <= 1'b1;
            end else if (par_fail) begin
              par_err <= 1'b1;
            end else begin
              p_data     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end

        default: begin
          state <= RX_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx with DATA_WIDTH = 8, OVERSAMPLE = 8. Frames are
// driven bit by bit on rx_in; a negedge monitor tallies output pulses and a
// log of received words, and each scenario compares the tallies against
// hand-computed values.
module tb_uart_rx;

  localparam int DATA_WIDTH = 8;
  localparam int OVERSAMPLE = 8;

  logic                  clk = 1'b0;
  logic                  res_n;
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  int num_checks = 0;
  int num_fail   = 0;

  int dv_cnt      = 0;
  int pe_cnt      = 0;
  int se_cnt      = 0;
  int busy_cycles = 0;
  logic [7:0] dv_log [0:63];

  int base_dv;
  int base_pe;
  int base_se;
  int base_busy;

  uart_rx #(
    .DATA_WIDTH (DATA_WIDTH),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse and busy tallies, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      if (dv_cnt < 64) dv_log[dv_cnt] = p_data;
      dv_cnt++;
    end
    if (par_err) pe_cnt++;
    if (stp_err) se_cnt++;
    if (busy)    busy_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold rx_in at 'val' for 'len' clocks; entered and left just after a posedge.
  task automatic driveBit(input logic val, input int len);
    rx_in = val;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  // jitter 0: nominal bits; 1: lengths 9,7,9,...; 2: lengths 7,9,7,...
  function automatic int bitLen(input int jitter, input int k);
    if (jitter == 1) return (k % 2 == 0) ? OVERSAMPLE + 1 : OVERSAMPLE - 1;
    if (jitter == 2) return (k % 2 == 0) ? OVERSAMPLE - 1 : OVERSAMPLE + 1;
    return OVERSAMPLE;
  endfunction

  // Drive one frame. flip_par_en toggles par_en right after the start bit to
  // show that mid-frame configuration changes have no effect.
  task automatic applyStimulus(input logic [7:0] data, input logic with_par,
                               input logic par_bit, input logic stop_bit,
                               input int jitter, input logic flip_par_en);
    int k;
    k = 0;
    driveBit(1'b0, bitLen(jitter, k));
    k++;
    if (flip_par_en) par_en = ~par_en;
    for (int i = 0; i < 8; i++) begin
      driveBit(data[i], bitLen(jitter, k));
      k++;
    end
    if (with_par) begin
      driveBit(par_bit, bitLen(jitter, k));
      k++;
    end
    driveBit(stop_bit, bitLen(jitter, k));
  endtask

  task automatic snap();
    base_dv   = dv_cnt;
    base_pe   = pe_cnt;
    base_se   = se_cnt;
    base_busy = busy_cycles;
  endtask

  task automatic expectGood(input string tag, input logic [7:0] data);
    checkOutput({tag, "_dv_count"}, 32'(dv_cnt - base_dv), 32'd1);
    checkOutput({tag, "_p_data"}, 32'(p_data), 32'(data));
  endtask

  initial begin
    res_n   = 1'b0;
    rx_in   = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_p_data", 32'(p_data), 32'h0);
    checkOutput("reset_data_valid", 32'(data_valid), 32'h0);
    checkOutput("reset_par_err", 32'(par_err), 32'h0);
    checkOutput("reset_stp_err", 32'(stp_err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    res_n = 1'b1;
    driveBit(1'b1, 10);

    // Good frame, no parity.
    snap();
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    expectGood("a5", 8'hA5);
    checkOutput("a5_dv_word", 32'(dv_log[base_dv]), 32'hA5);
    checkOutput("a5_no_par_err", 32'(pe_cnt - base_pe), 32'd0);
    checkOutput("a5_no_stp_err", 32'(se_cnt - base_se), 32'd0);
    checkOutput("a5_busy_cycles", 32'(busy_cycles - base_busy), 32'd77);

    // Even parity, correct parity bit.
    par_en  = 1'b1;
    par_typ = 1'b0;
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    expectGood("even_ok", 8'h3C);

    // Even parity, wrong parity bit: p_data must hold 0x3C.
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("even_bad_par_err", 32'(pe_cnt - base_pe), 32'd1);
    checkOutput("even_bad_no_dv", 32'(dv_cnt - base_dv), 32'd0);
    checkOutput("even_bad_p_data_held", 32'(p_data), 32'h3C);

    // Odd parity, 0x3C has four ones so the parity bit must be 1.
    par_typ = 1'b1;
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("odd_ok_dv_count", 32'(dv_cnt - base_dv), 32'd1);
    checkOutput("odd_ok_no_par_err", 32'(pe_cnt - base_pe), 32'd0);

    // Framing error, then a good frame.
    par_en  = 1'b0;
    par_typ = 1'b0;
    snap();
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("frame_stp_err", 32'(se_cnt - base_se), 32'd1);
    checkOutput("frame_no_dv", 32'(dv_cnt - base_dv), 32'd0);
    checkOutput("frame_no_par_err", 32'(pe_cnt - base_pe), 32'd0);
    checkOutput("frame_p_data_held", 32'(p_data), 32'h3C);
    snap();
    applyStimulus(8'h12, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    expectGood("after_frame_err", 8'h12);

    // Glitch: 3 low clocks. busy spans detect+1 .. vote cycle (cnt 1..5).
    snap();
    driveBit(1'b0, 3);
    driveBit(1'b1, 20);
    checkOutput("glitch_busy_cycles", 32'(busy_cycles - base_busy), 32'd5);
    checkOutput("glitch_no_pulses",
                32'((dv_cnt - base_dv) + (pe_cnt - base_pe) + (se_cnt - base_se)), 32'd0);
    checkOutput("glitch_busy_low", 32'(busy), 32'h0);
    snap();
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    expectGood("after_glitch", 8'h81);

    // Back-to-back frames with +-1 clock bit-edge jitter.
    snap();
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("b2b_dv_count", 32'(dv_cnt - base_dv), 32'd2);
    checkOutput("b2b_first_word", 32'(dv_log[base_dv]), 32'h01);
    checkOutput("b2b_second_word", 32'(dv_log[base_dv + 1]), 32'hFF);
    checkOutput("b2b_no_errors", 32'((pe_cnt - base_pe) + (se_cnt - base_se)), 32'd0);

    // par_en raised mid-frame must be ignored: no parity slot is expected.
    par_en = 1'b0;
    snap();
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    driveBit(1'b1, 20);
    checkOutput("latch_cfg_dv_count", 32'(dv_cnt - base_dv), 32'd1);
    checkOutput("latch_cfg_no_par_err", 32'(pe_cnt - base_pe), 32'd0);
    par_en = 1'b0;

    // Reset during data bit 4 of 0xF0; bits 4..7 and stop are high so the
    // remainder carries no falling edge.
    snap();
    driveBit(1'b0, 8);
    for (int i = 0; i < 4; i++) driveBit(1'b0, 8);
    driveBit(1'b1, 4);
    checkOutput("mid_reset_busy_before", 32'(busy), 32'h1);
    res_n = 1'b0;
    @(posedge clk);
    #1;
    res_n = 1'b1;
    checkOutput("mid_reset_p_data", 32'(p_data), 32'h0);
    checkOutput("mid_reset_busy", 32'(busy), 32'h0);
    checkOutput("mid_reset_pulses", 32'({data_valid, par_err, stp_err}), 32'h0);
    driveBit(1'b1, 3 + 24 + 8);
    driveBit(1'b1, 20);
    checkOutput("mid_reset_remainder_quiet",
                32'((dv_cnt - base_dv) + (pe_cnt - base_pe) + (se_cnt - base_se)), 32'd0);
    snap();
    applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    driveBit(1'b1, 20);
    expectGood("after_reset", 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
